// File: rtl/sys_arr_pkg.sv
// sys_arr_pkg: shared widths, feeder FSM states and drain length for the systolic array slice
package sys_arr_pkg;
  localparam int DATA_W = 8;
  localparam int SUM_W = 16;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} feed_state_t;
  function automatic int drain_len(input int w);
    return 2 * w - 1;
  endfunction
endpackage

// File: rtl/sys_arr_fifo.sv
// sys_arr_fifo: sync FIFO; ports clock/reset_n/clear, push/wdata in, pop/rdata out, full/empty/count status
module sys_arr_fifo #(
  parameter int width = 17,
  parameter int depth = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic [width-1:0]         wdata,
  input  logic                     pop,
  output logic [width-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(depth):0]   count
);
  localparam int AW = $clog2(depth);
  localparam int CNTW = AW + 1;
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(depth);
  logic [width-1:0] mem [depth];
  logic [AW-1:0] wptr, rptr;
  logic wr, rd;
  assign full = count == FULL_CNT;
  assign empty = count == '0;
  assign wr = push && !full;
  assign rd = pop && !empty;
  assign rdata = mem[rptr];
  always_ff @(posedge clock) if (wr) mem[wptr] <= wdata;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else if (clear) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      count <= count + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
    end
endmodule

// File: rtl/sys_arr_feeder.sv
// sys_arr_feeder: buffers s_data vectors, skews row i by i cycles onto datain/lane_valid, drives active/tile_done/busy
module sys_arr_feeder
  import sys_arr_pkg::*;
#(
  parameter int width_height = 2,
  parameter int fifo_depth = 4
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             clear,
  input  logic [DATA_W*width_height-1:0]   s_data,
  input  logic                             s_last,
  input  logic                             s_valid,
  output logic                             s_ready,
  output logic [DATA_W*width_height-1:0]   datain,
  output logic [width_height-1:0]          lane_valid,
  output logic                             active,
  output logic                             tile_done,
  output logic                             busy
);
  localparam int VW = DATA_W * width_height;
  localparam int CW = $clog2(2 * width_height);
  localparam int CNTW = $clog2(fifo_depth) + 1;
  localparam logic [CW-1:0] DRAIN_CNT = CW'(drain_len(width_height));
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CNTW-1:0] FD = CNTW'(fifo_depth);
  feed_state_t state;
  logic [CW-1:0] drain_cnt;
  logic [VW:0] rdata;
  logic [CNTW-1:0] count;
  logic full, empty, pop;
  logic [VW-1:0] inj_data;
  assign s_ready = count < FD;
  assign busy = state != IDLE;
  assign pop = state == STREAM && !empty;
  assign inj_data = pop ? rdata[VW-1:0] : '0;
  sys_arr_fifo #(.width(VW + 1), .depth(fifo_depth)) u_fifo (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (clear),
    .push   (s_valid && !full),
    .wdata  ({s_last, s_data}),
    .pop    (pop),
    .rdata  (rdata),
    .full   (full),
    .empty  (empty),
    .count  (count)
  );
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      drain_cnt <= '0;
      active <= 1'b0;
      tile_done <= 1'b0;
    end else if (clear) begin
      state <= IDLE;
      drain_cnt <= '0;
      active <= 1'b0;
      tile_done <= 1'b0;
    end else begin
      active <= state != IDLE;
      tile_done <= 1'b0;
      case (state)
        IDLE: if (!empty) state <= STREAM;
        STREAM:
          if (pop && rdata[VW]) begin
            state <= DRAIN;
            drain_cnt <= DRAIN_CNT;
            tile_done <= DRAIN_CNT == ONE;
          end
        DRAIN: begin
          drain_cnt <= drain_cnt - 1'b1;
          tile_done <= (drain_cnt - 1'b1) == ONE;
          if (drain_cnt == ONE) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  for (genvar l = 0; l < width_height; l++) begin : g_lane
    logic [DATA_W:0] sr [l+1];
    always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
        for (int k = 0; k <= l; k++) sr[k] <= '0;
      end else if (clear) begin
        for (int k = 0; k <= l; k++) sr[k] <= '0;
      end else begin
        sr[0] <= {pop, inj_data[l*DATA_W +: DATA_W]};
        for (int k = 1; k <= l; k++) sr[k] <= sr[k-1];
      end
    assign {lane_valid[l], datain[l*DATA_W +: DATA_W]} = sr[l];
  end
endmodule

// File: tb/tb_sys_arr_feeder.sv
// tb_sys_arr_feeder: directed and random stimulus against a queue-based model of the feeder
module tb_sys_arr_feeder;
  localparam int W = 2;
  localparam int D = 4;
  localparam int VW = 8 * W;
  logic clock = 0, reset_n = 0, clear = 0, s_last = 0, s_valid = 0;
  logic [VW-1:0] s_data = '0;
  logic s_ready, active, tile_done, busy;
  logic [VW-1:0] datain;
  logic [W-1:0] lane_valid;
  int passes = 0, total = 0;
  int act_cnt = 0, done_cnt = 0;
  bit saw_full = 0;
  logic [VW:0] q[$];
  logic [VW:0] hist [W];
  bit engaged, acc, exp_active, exp_done;
  int drain_left;
  sys_arr_feeder #(.width_height(W), .fifo_depth(D)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (clear),
    .s_data    (s_data),
    .s_last    (s_last),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .datain    (datain),
    .lane_valid(lane_valid),
    .active    (active),
    .tile_done (tile_done),
    .busy      (busy)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
  endtask
  task automatic model_clear();
    q.delete();
    engaged = 0;
    drain_left = 0;
    exp_active = 0;
    exp_done = 0;
    acc = 0;
    for (int k = 0; k < W; k++) hist[k] = '0;
  endtask
  task automatic model_edge();
    logic [VW:0] inj = '0;
    if (!reset_n || clear) begin
      model_clear();
      return;
    end
    acc = s_valid && q.size() < D;
    exp_active = engaged;
    if (engaged && drain_left == 0) begin
      if (q.size() > 0) begin
        inj = q.pop_front();
        if (inj[VW]) drain_left = 2 * W - 1;
        inj[VW] = 1'b1;
      end
    end else if (engaged) begin
      drain_left--;
      if (drain_left == 0) engaged = 0;
    end else if (q.size() > 0) engaged = 1;
    exp_done = engaged && drain_left == 1;
    if (acc) q.push_back({s_last, s_data});
    for (int k = W - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = inj;
  endtask
  task automatic compare_all();
    logic [VW-1:0] ed;
    logic [W-1:0] ev;
    for (int i = 0; i < W; i++) begin
      ed[8*i +: 8] = hist[i][8*i +: 8];
      ev[i] = hist[i][VW];
    end
    chk("datain", datain, ed);
    chk("lane_valid", lane_valid, ev);
    chk("active", active, exp_active);
    chk("tile_done", tile_done, exp_done);
    chk("busy", busy, engaged);
    chk("s_ready", s_ready, q.size() < D);
  endtask
  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    compare_all();
    if (active) act_cnt++;
    if (tile_done) done_cnt++;
    if (!s_ready) saw_full = 1;
  endtask
  task automatic push(input logic [VW-1:0] d, input logic l);
    s_valid = 1;
    s_data = d;
    s_last = l;
    step();
    s_valid = 0;
    s_last = 0;
  endtask
  task automatic settle();
    int n = 0;
    while ((engaged || q.size() > 0 || exp_active) && n < 100) begin
      step();
      n++;
    end
    chk("settle", n < 100, 1);
    step();
  endtask
  task automatic push_held(input int cnt, input bit last_at_end);
    s_valid = 1;
    for (int j = 1; j <= cnt; j++) begin
      int n = 0;
      s_data = VW'(16'h1000 + j);
      s_last = last_at_end && j == cnt;
      do begin
        step();
        n++;
      end while (!acc && n < 20);
      chk("held_accept", n < 20, 1);
    end
    s_valid = 0;
    s_last = 0;
  endtask
  task automatic single_tile();
    act_cnt = 0;
    done_cnt = 0;
    push(16'h0201, 0);
    push(16'h0403, 1);
    settle();
    chk("tile_active_len", act_cnt, 5);
    chk("tile_done_cnt", done_cnt, 1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
  initial begin
    int n;
    model_clear();
    s_valid = 1;
    s_data = 16'hbeef;
    s_last = 1;
    repeat (3) step();
    s_valid = 0;
    s_last = 0;
    reset_n = 1;
    step();
    chk("ready_after_rst", s_ready, 1);
    single_tile();
    saw_full = 0;
    push(16'ha5a5, 1);
    push_held(5, 1);
    settle();
    chk("saw_full", saw_full, 1);
    act_cnt = 0;
    done_cnt = 0;
    push(16'h1111, 0);
    repeat (3) step();
    push(16'h2222, 1);
    settle();
    chk("bubble_active_len", act_cnt, 7);
    chk("bubble_done_cnt", done_cnt, 1);
    push(16'h7777, 1);
    push_held(4, 0);
    n = 0;
    while (!(engaged && drain_left == 0 && q.size() == 3) && n < 30) begin
      step();
      n++;
    end
    chk("clr_reach", n < 30, 1);
    done_cnt = 0;
    clear = 1;
    step();
    clear = 0;
    chk("clr_busy", busy, 0);
    chk("clr_active", active, 0);
    chk("clr_ready", s_ready, 1);
    repeat (4) step();
    chk("clr_no_done", done_cnt, 0);
    single_tile();
    push(16'h3344, 0);
    push(16'h5566, 1);
    n = 0;
    while (drain_left != 3 && n < 20) begin
      step();
      n++;
    end
    chk("drain_reach", n < 20, 1);
    done_cnt = 0;
    #2 reset_n = 0;
    #1;
    chk("arst_datain", datain, 0);
    chk("arst_lane_valid", lane_valid, 0);
    chk("arst_active", active, 0);
    chk("arst_tile_done", tile_done, 0);
    chk("arst_busy", busy, 0);
    model_clear();
    step();
    reset_n = 1;
    repeat (4) step();
    chk("arst_no_done", done_cnt, 0);
    chk("arst_idle", busy, 0);
    for (int c = 0; c < 3000; c++) begin
      s_valid = $urandom_range(0, 99) < 60;
      s_last = $urandom_range(0, 3) == 0;
      s_data = VW'($urandom);
      clear = $urandom_range(0, 99) < 2;
      step();
    end
    clear = 0;
    s_valid = 0;
    s_last = 0;
    settle();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/sys_arr_feeder.md
Name: sys_arr_feeder

Overview:
- Upstream feeder for the weight-stationary systolic array; drives its `datain` and `active` inputs.
- Accepts one activation vector per beat (8 bits per row, row 0 in the LSBs) over a valid/ready handshake and buffers vectors in a small FIFO.
- Applies the diagonal skew the array needs: row i is delayed i cycles.
- Holds `active` high through the tile plus a drain window, then pulses `tile_done` so the downstream result collector knows the tile has flushed.

Parameters:
- width_height, 2: array rows/columns; must match the array instance.
- fifo_depth, 4: vectors buffered; power of two, >= 2.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush; aborts the tile.
- s_data  in  8*width_height  input vector, lane i = bits [8i+7:8i].
- s_last  in  1  marks the final vector of a tile.
- s_valid  in  1  input vector valid.
- s_ready  out  1  FIFO can accept a vector.
- datain  out  8*width_height  skewed data to the array.
- lane_valid  out  width_height  per-row flag; 1 = real data, 0 = bubble/drain zero.
- active  out  1  array enable.
- tile_done  out  1  one-cycle pulse at end of drain.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async, reset_n=0): FIFO empty, skew registers 0, FSM=IDLE. Outputs: datain=0, lane_valid=0, active=0, tile_done=0, busy=0. s_ready=1 once the FIFO is empty.
- FIFO:
  - Entry = {s_last, s_data}.
  - s_ready = (count < fifo_depth), computed from the registered count only; no pop-through when full.
  - Push when s_valid && s_ready.
  - A push into an empty FIFO is not bypassed; it is poppable the next cycle.
  - Simultaneous push and pop: count unchanged, pointers wrap modulo fifo_depth.
- FSM states IDLE, STREAM, DRAIN:
  - IDLE -> STREAM when the FIFO is non-empty. The first pop happens in the first STREAM cycle.
  - STREAM: pop one entry every cycle the FIFO is non-empty. If the FIFO is empty, inject a bubble: zero vector, valid bit 0, no pop.
  - STREAM -> DRAIN in the cycle after popping an entry with last=1. Load drain_cnt = 2*width_height-1.
  - DRAIN: inject zero vectors with valid 0 and decrement drain_cnt. When drain_cnt reaches 1, the next state is IDLE and tile_done pulses in the final DRAIN cycle.
  - FIFO pushes continue during DRAIN. The next tile starts only after returning to IDLE; the minimum gap is 1 cycle.
- Skew pipeline:
  - The stage-0 register captures the popped (or injected) vector plus its valid bit.
  - Lane i then passes through i further registers.
  - datain lane i and lane_valid[i] are therefore 1+i cycles after the pop.
  - All outputs are registered.
- active:
  - Registered; high from the cycle lane 0 of the tile's first vector appears on datain until the cycle after tile_done.
  - Length = (popped vectors + bubbles) + 2*width_height-1 cycles.
  - busy is high in STREAM and DRAIN.
- clear (higher priority than all else except reset): next cycle FIFO empty, skew registers 0, FSM=IDLE, active=0, no tile_done.
- Reset mid-tile: identical to the reset state immediately (async); no partial tile_done.
- Widths: FIFO pointers and count use $clog2(fifo_depth) and $clog2(fifo_depth)+1 bits. drain_cnt uses $clog2(2*width_height) bits. No arithmetic on data; lanes pass unmodified.

Decomposition:
- Shared package sys_arr_pkg holds:
  - DATA_W=8 and SUM_W=16;
  - the FSM state enum {IDLE, STREAM, DRAIN};
  - the function drain_len(w) = 2*w-1, which is reused by the downstream collector.
- One natural sub-module: sys_arr_fifo, a synchronous FIFO parameterised by width and depth with full/empty/count outputs.
- Skew registers and the FSM stay in sys_arr_feeder.

Test Plan:
- Reset: hold reset_n=0 with s_valid=1 -> datain=0, active=0, lane_valid=0, busy=0. s_ready=1 one cycle after release.
- Single tile, width_height=2: push A=16'h0201 then B=16'h0403 with last, back to back. Required response:
  - datain[7:0] shows 01 then 03;
  - datain[15:8] shows 02 then 04, one cycle later;
  - active is high for 2+3=5 cycles;
  - tile_done pulses once, coincident with the last active cycle's predecessor;
  - lane_valid is low during drain.
- Backpressure: hold the feeder before streaming and push 4 vectors -> s_ready=0 after the 4th. A 5th push is held with s_valid=1 and is accepted in the cycle after the first pop, with no loss or duplication across pointer wrap.
- Bubble: push vector 8'h11 lanes without last, wait 2 cycles, then push last -> two zero bubbles with lane_valid=0 between them; active stays high, total active = 1+2+1+3 = 7 cycles.
- Clear mid-STREAM with 3 vectors queued -> next cycle FIFO empty, active=0, busy=0. No tile_done; a subsequent fresh tile behaves as in the single-tile case.
- Async reset asserted mid-DRAIN (between clock edges) -> outputs 0 immediately, no tile_done pulse, FSM in IDLE after release.
